// File: rtl/fast_square_pkg.sv
// ============================================================================
// fast_square_pkg : shared types and helpers for the comb-and-decimate stage
// Revision        : 1.0
// ============================================================================
`default_nettype none

package fast_square_pkg;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BLANK  = 2'd1,
    STREAM = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HIGH = 2'd1,
    SAT_LOW  = 2'd2
  } sat_t;

  // Blanking word: only the MSB of a width-bit sample is set.
  function automatic logic [63:0] blank_word(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // Classifies a wide signed value against the signed range of 'width' bits.
  function automatic sat_t saturate(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    if (value > hi) return SAT_HIGH;
    if (value < (-hi - 64'sd1)) return SAT_LOW;
    return SAT_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fast_square_comb_stage.sv
// ============================================================================
// fast_square_comb_stage : one registered comb section y[n] = x[n] - x[n-D]
// Revision               : 1.0
// ============================================================================
`default_nettype none

module fast_square_comb_stage #(
  parameter int WIDTH_IN = 16,
  parameter int DELAY    = 1
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       bypass,
  input  logic signed [WIDTH_IN-1:0] x,
  output logic signed [WIDTH_IN:0]   y
);

  logic signed [WIDTH_IN-1:0] r_dline [DELAY];

  // Delay line keeps running in bypass so a later switch back sees real history.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DELAY; i++) r_dline[i] <= '0;
      y <= '0;
    end else begin
      r_dline[0] <= x;
      for (int i = 1; i < DELAY; i++) r_dline[i] <= r_dline[i-1];
      if (bypass) y <= (WIDTH_IN+1)'(x);
      else        y <= (WIDTH_IN+1)'(x) - (WIDTH_IN+1)'(r_dline[DELAY-1]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fast_square_comb_decim.sv
// ============================================================================
// fast_square_comb_decim : I/Q comb cascade, decimating strobe and
//                          header/blank/stream framing with restart counting
// Revision               : 1.0
// ============================================================================
`default_nettype none

module fast_square_comb_decim
  import fast_square_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int COMB_STAGES  = 2,
  parameter int COMB_DELAY   = 1,
  parameter int DECIM        = 33,
  parameter int BLANK_FRAMES = 101,
  parameter int MOD_COUNT    = 5,
  parameter int MODW         = $clog2(MOD_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ext_reset,
  input  logic                    comb_bypass,
  input  logic signed [WIDTH-1:0] i_in,
  input  logic signed [WIDTH-1:0] q_in,
  output logic                    data_out_strobe,
  output logic                    header,
  output logic                    blanking,
  output logic signed [WIDTH-1:0] i_out,
  output logic signed [WIDTH-1:0] q_out,
  output logic [MODW-1:0]         mod_counter
);

  localparam int CNTW = $clog2(DECIM);
  localparam int BW   = $clog2(BLANK_FRAMES + 1);
  localparam int OUTW = WIDTH + COMB_STAGES;
  localparam int NRW  = 2 * WIDTH;
  localparam logic [63:0]      BLANK_FULL = blank_word(WIDTH);
  localparam logic [WIDTH-1:0] BLANK_WORD = BLANK_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_clear;
  assign w_clear = reset | ext_reset;

  // ---------------------------------------------------------------- strobe
  logic [CNTW-1:0] r_div_cnt;
  logic            w_strobe_pt;

  assign w_strobe_pt     = (r_div_cnt == CNTW'(DECIM - 1));
  assign data_out_strobe = w_strobe_pt & ~w_clear;

  always_ff @(posedge clock) begin
    if (w_clear || w_strobe_pt) r_div_cnt <= '0;
    else                        r_div_cnt <= r_div_cnt + CNTW'(1);
  end

  // ---------------------------------------------------------------- combs
  // Taps are carried sign-extended at full output width; each stage only
  // consumes the low bits that its growing width actually needs.
  logic signed [OUTW-1:0] w_i_tap [COMB_STAGES+1];
  logic signed [OUTW-1:0] w_q_tap [COMB_STAGES+1];

  assign w_i_tap[0] = OUTW'(i_in);
  assign w_q_tap[0] = OUTW'(q_in);

  for (genvar k = 0; k < COMB_STAGES; k++) begin : g_comb
    logic signed [WIDTH+k:0] w_i_y;
    logic signed [WIDTH+k:0] w_q_y;

    fast_square_comb_stage #(.WIDTH_IN(WIDTH + k), .DELAY(COMB_DELAY)) u_i_stage (
      .clock  (clock),
      .clear  (w_clear),
      .bypass (comb_bypass),
      .x      (w_i_tap[k][WIDTH+k-1:0]),
      .y      (w_i_y)
    );

    fast_square_comb_stage #(.WIDTH_IN(WIDTH + k), .DELAY(COMB_DELAY)) u_q_stage (
      .clock  (clock),
      .clear  (w_clear),
      .bypass (comb_bypass),
      .x      (w_q_tap[k][WIDTH+k-1:0]),
      .y      (w_q_y)
    );

    assign w_i_tap[k+1] = OUTW'(w_i_y);
    assign w_q_tap[k+1] = OUTW'(w_q_y);
  end

  sat_t             w_i_dir, w_q_dir;
  logic [WIDTH-1:0] w_i_sat, w_q_sat;

  assign w_i_dir = saturate(64'(w_i_tap[COMB_STAGES]), WIDTH);
  assign w_q_dir = saturate(64'(w_q_tap[COMB_STAGES]), WIDTH);

  always_comb begin
    w_i_sat = w_i_tap[COMB_STAGES][WIDTH-1:0];
    w_q_sat = w_q_tap[COMB_STAGES][WIDTH-1:0];
    if (w_i_dir == SAT_HIGH)     w_i_sat = SAT_MAX;
    else if (w_i_dir == SAT_LOW) w_i_sat = SAT_MIN;
    if (w_q_dir == SAT_HIGH)     w_q_sat = SAT_MAX;
    else if (w_q_dir == SAT_LOW) w_q_sat = SAT_MIN;
  end

  // ---------------------------------------------------------------- FSM
  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_blank_cnt, w_blank_nxt;
  logic [NRW-1:0]  r_num_resets, w_num_nxt;
  logic [MODW-1:0] r_mod, w_mod_nxt;

  always_ff @(posedge clock) begin
    if (ext_reset) begin
      r_state      <= HEADER;
      r_blank_cnt  <= '0;
      r_num_resets <= '0;
      r_mod        <= '0;
    end else if (reset) begin
      r_state     <= HEADER;
      r_blank_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_blank_cnt  <= w_blank_nxt;
      r_num_resets <= w_num_nxt;
      r_mod        <= w_mod_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blank_nxt = r_blank_cnt;
    w_num_nxt   = r_num_resets;
    w_mod_nxt   = r_mod;
    if (w_strobe_pt) begin
      case (r_state)
        HEADER: begin
          w_state_nxt = BLANK;
          w_num_nxt   = r_num_resets + NRW'(1);
          w_mod_nxt   = (r_mod == MODW'(MOD_COUNT - 1)) ? '0 : r_mod + MODW'(1);
        end
        BLANK: begin
          if (r_blank_cnt == BW'(BLANK_FRAMES - 1)) begin
            w_state_nxt = STREAM;
            w_blank_nxt = '0;
          end else begin
            w_blank_nxt = r_blank_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    header   = 1'b0;
    blanking = 1'b0;
    i_out    = w_i_sat;
    q_out    = w_q_sat;
    case (r_state)
      HEADER: begin
        header = 1'b1;
        i_out  = r_num_resets[WIDTH-1:0];
        q_out  = r_num_resets[NRW-1:WIDTH];
      end
      BLANK: begin
        blanking = 1'b1;
        i_out    = BLANK_WORD;
        q_out    = BLANK_WORD;
      end
      default: ;
    endcase
  end

  assign mod_counter = r_mod;

endmodule

`default_nettype wire

// File: tb/tb_fast_square_comb_decim.sv
// ============================================================================
// tb_fast_square_comb_decim : directed self-checking bench, default parameters
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_fast_square_comb_decim;

  logic               clock = 1'b0;
  logic               reset, ext_reset, comb_bypass;
  logic signed [15:0] i_in, q_in, i_out, q_out;
  logic               data_out_strobe, header, blanking;
  logic [2:0]         mod_counter;

  int checks   = 0;
  int failures = 0;

  fast_square_comb_decim dut (
    .clock           (clock),
    .reset           (reset),
    .ext_reset       (ext_reset),
    .comb_bypass     (comb_bypass),
    .i_in            (i_in),
    .q_in            (q_in),
    .data_out_strobe (data_out_strobe),
    .header          (header),
    .blanking        (blanking),
    .i_out           (i_out),
    .q_out           (q_out),
    .mod_counter     (mod_counter)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic to_next_strobe(input int n, input string tag);
    repeat (n) tick();
    chk(tag, 64'(data_out_strobe), 64'sd1);
  endtask

  // From a strobe cycle, place one +1000 sample k cycles ahead of the next strobe.
  task automatic impulse(input int k, input logic signed [63:0] exp);
    repeat (33 - k) tick();
    i_in = 16'sd1000;
    tick();
    i_in = 16'sd0;
    repeat (k - 1) tick();
    chk("imp_strobe", 64'(data_out_strobe), 64'sd1);
    chk("imp_i_out", 64'(i_out), exp);
    chk("imp_q_out", 64'(q_out), 64'sd0);
  endtask

  task automatic blank_run(input int first_gap, input string tag);
    for (int b = 0; b < 101; b++) begin
      to_next_strobe((b == 0) ? first_gap : 33, tag);
      chk("blank_flag", 64'(blanking), 64'sd1);
      chk("blank_i", 64'(i_out), -64'sd32768);
      chk("blank_q", 64'(q_out), -64'sd32768);
    end
  endtask

  initial begin
    reset = 1'b0; ext_reset = 1'b0; comb_bypass = 1'b0;
    i_in = 16'sd100; q_in = 16'sd100;
    tick(); tick();

    // ---- constant input after ext_reset
    ext_reset = 1'b1;
    tick();
    ext_reset = 1'b0;
    chk("rst_strobe", 64'(data_out_strobe), 64'sd0);
    chk("rst_header", 64'(header), 64'sd1);
    chk("rst_blanking", 64'(blanking), 64'sd0);
    chk("rst_mod", 64'(mod_counter), 64'sd0);
    chk("rst_i_out", 64'(i_out), 64'sd0);
    // Edge that sampled ext_reset plus 32 more gives the 33rd edge.
    repeat (31) tick();
    chk("no_early_strobe", 64'(data_out_strobe), 64'sd0);
    to_next_strobe(1, "first_strobe");
    chk("hdr_flag", 64'(header), 64'sd1);
    chk("hdr_i", 64'(i_out), 64'sd0);
    chk("hdr_q", 64'(q_out), 64'sd0);
    chk("hdr_mod_pre", 64'(mod_counter), 64'sd0);
    tick();
    chk("hdr_mod_post", 64'(mod_counter), 64'sd1);
    chk("blank_enter", 64'(blanking), 64'sd1);
    blank_run(32, "blank_strobe");
    to_next_strobe(33, "stream_strobe");
    chk("stream_blank", 64'(blanking), 64'sd0);
    chk("stream_hdr", 64'(header), 64'sd0);
    chk("const_i", 64'(i_out), 64'sd0);
    chk("const_q", 64'(q_out), 64'sd0);

    // ---- impulse response taps 1000, -2000, 1000
    i_in = 16'sd0; q_in = 16'sd0;
    impulse(2, 64'sd1000);
    impulse(3, -64'sd2000);
    impulse(4, 64'sd1000);
    to_next_strobe(33, "imp_tail_strobe");
    chk("imp_tail", 64'(i_out), 64'sd0);

    // ---- full-scale toggle saturates without wrap
    for (int j = 0; j < 66; j++) begin
      i_in = (j % 2 == 0) ? 16'sd32767 : -16'sd32768;
      q_in = ~i_in;
      tick();
      if (j == 32) begin
        chk("sat_strobe_a", 64'(data_out_strobe), 64'sd1);
        chk("sat_i_low", 64'(i_out), -64'sd32768);
        chk("sat_q_high", 64'(q_out), 64'sd32767);
      end
    end
    chk("sat_strobe_b", 64'(data_out_strobe), 64'sd1);
    chk("sat_i_high", 64'(i_out), 64'sd32767);
    chk("sat_q_low", 64'(q_out), -64'sd32768);
    i_in = 16'sd0; q_in = 16'sd0;

    // ---- six plain resets: header counts and slot sequence
    ext_reset = 1'b1;
    tick();
    ext_reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      to_next_strobe(32, "rs_strobe");
      chk("rs_header", 64'(header), 64'sd1);
      chk("rs_count", 64'(i_out), 64'(n));
      chk("rs_count_hi", 64'(q_out), 64'sd0);
      chk("rs_mod_pre", 64'(mod_counter), 64'(n % 5));
      tick();
      chk("rs_mod_post", 64'(mod_counter), 64'((n + 1) % 5));
    end

    // ---- reset in the middle of blanking
    for (int b = 0; b < 50; b++) begin
      to_next_strobe((b == 0) ? 32 : 33, "mid_blank_strobe");
      chk("mid_blank_flag", 64'(blanking), 64'sd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_header", 64'(header), 64'sd1);
    chk("mid_rst_strobe", 64'(data_out_strobe), 64'sd0);
    to_next_strobe(32, "mid_hdr_strobe");
    chk("mid_hdr_count", 64'(i_out), 64'sd6);
    chk("mid_hdr_mod", 64'(mod_counter), 64'sd1);
    tick();
    chk("mid_mod_post", 64'(mod_counter), 64'sd2);
    blank_run(32, "mid_blank_run");
    to_next_strobe(33, "mid_stream_strobe");
    chk("mid_stream_blank", 64'(blanking), 64'sd0);

    // ---- simultaneous reset and ext_reset, then bypass toggling
    reset = 1'b1; ext_reset = 1'b1;
    tick();
    reset = 1'b0; ext_reset = 1'b0;
    to_next_strobe(32, "both_hdr_strobe");
    chk("both_count", 64'(i_out), 64'sd0);
    chk("both_count_hi", 64'(q_out), 64'sd0);
    chk("both_mod", 64'(mod_counter), 64'sd0);
    tick();
    chk("both_mod_post", 64'(mod_counter), 64'sd1);
    blank_run(32, "both_blank_run");
    to_next_strobe(33, "both_stream_strobe");
    comb_bypass = 1'b1;
    for (int j = 0; j < 33; j++) begin
      i_in = 16'(j * 100);
      q_in = 16'(-j * 10);
      tick();
    end
    chk("byp_strobe", 64'(data_out_strobe), 64'sd1);
    chk("byp_i", 64'(i_out), 64'sd3100);
    chk("byp_q", 64'(q_out), -64'sd310);
    comb_bypass = 1'b0;
    for (int j = 33; j < 66; j++) begin
      i_in = 16'(j * 100);
      q_in = 16'(-j * 10);
      tick();
    end
    chk("ramp_strobe", 64'(data_out_strobe), 64'sd1);
    chk("ramp_i", 64'(i_out), 64'sd0);
    chk("ramp_q", 64'(q_out), 64'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
